// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART program loader.
//   state_t           : loader FSM state encoding
//   SYNC_BYTE_DEFAULT : default packet start marker
//   ADDR_BYTES, CNT_BYTES, WORD_BYTES : packet field lengths in bytes
//   field_last()      : index of the final byte of a multi-byte field
//   timed_state()     : states in which the inter-byte timeout is armed
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CNT,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_RUN
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int          ADDR_BYTES  = 4;
    localparam int          CNT_BYTES   = 2;
    localparam int          WORD_BYTES  = 4;

    localparam logic [31:0] WORD_STRIDE = 32'd4;

    // Index of the last byte of the field collected in the given state.
    function automatic logic [1:0] field_last(input state_t s);
        case (s)
            ST_ADDR: field_last = 2'(ADDR_BYTES - 1);
            ST_CNT:  field_last = 2'(CNT_BYTES - 1);
            ST_DATA: field_last = 2'(WORD_BYTES - 1);
            default: field_last = 2'd0;
        endcase
    endfunction

    // States that are waiting on the line for the next packet byte.
    function automatic logic timed_state(input state_t s);
        timed_state = (s == ST_ADDR) || (s == ST_CNT) ||
                      (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// ---------------------------------------------------------------------------
// loader_timeout
// Inter-byte idle counter for the UART loader.
//   clk, resetn : system clock, synchronous active-low reset
//   clear       : restart the count from zero (takes priority over run)
//   run         : count one per clock while high; hold while low
//   expired     : high while run is set and TIMEOUT_CYCLES clocks have
//                 elapsed since the last clear
// ---------------------------------------------------------------------------
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // The clear cycle itself is the first idle cycle, so the limit is one
    // less than the timeout: expiry is acted on exactly TIMEOUT_CYCLES
    // clocks after the clearing edge.
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturating idle counter; it stops at the limit so it can never wrap
    // back below it while the line stays quiet.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && (count >= LIMIT);

endmodule

// File: rtl/uart_loader_ctrl.sv
// ---------------------------------------------------------------------------
// uart_loader_ctrl
// Receives a program image over a UART byte stream, writes it to memory one
// 32-bit word at a time and releases the CPU from reset once the packet
// checksum matches.
//
// Packet: SYNC_BYTE, ADDR[4] LE, COUNT[2] LE (words), DATA[4*COUNT] LE,
//         CSUM[1] = 8-bit sum of every byte after SYNC through the last DATA.
//
//   clk, resetn       : system clock, synchronous active-low reset
//   rx_valid, rx_data : one-cycle strobe with a received byte
//   rx_break          : line BREAK, qualified by rx_valid
//   uart_rx_en        : receiver enable (high whenever out of reset)
//   mem_req/addr/wdata: word write request, held until mem_ack
//   mem_ack           : memory accepted the write this cycle
//   cpu_resetn        : CPU reset, released only in RUN
//   load_done         : pulse, packet loaded with a good checksum
//   load_err          : pulse, packet aborted
//   busy              : packet reception or write in progress
// ---------------------------------------------------------------------------
module uart_loader_ctrl
    import loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_break,
    output logic        uart_rx_en,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        cpu_resetn,
    output logic        load_done,
    output logic        load_err,
    output logic        busy
);

    state_t      state;
    state_t      state_next;

    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic [15:0] word_cnt;

    logic        byte_last;
    logic [15:0] count_full;

    logic        byte_take;
    logic        write_step;
    logic        abort;
    logic        done_set;
    logic        err_set;

    logic        timer_clear;
    logic        timer_run;
    logic        timer_expired;

    // Decoded straight from the state register so mem_req and cpu_resetn
    // follow a reset or an abort on the very next cycle.
    assign busy       = (state != ST_IDLE) && (state != ST_RUN);
    assign mem_req    = (state == ST_WRITE);
    assign cpu_resetn = (state == ST_RUN);

    assign byte_last  = (byte_cnt == field_last(state));

    // The COUNT field is assembled little-endian into word_cnt; this is the
    // value it will hold once the current byte lands.
    assign count_full = {rx_data, word_cnt[15:8]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. A BREAK wins over everything, then the idle
    // timeout, then the per-state byte handling.
    always_comb begin
        state_next = state;
        byte_take  = 1'b0;
        write_step = 1'b0;
        abort      = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;

        if (rx_valid && rx_break) begin
            state_next = ST_IDLE;
            abort      = busy;
            err_set    = busy;
        end else if (timer_expired) begin
            state_next = ST_IDLE;
            abort      = 1'b1;
            err_set    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_next = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        byte_take = 1'b1;
                        if (byte_last) begin
                            state_next = ST_CNT;
                        end
                    end
                end
                ST_CNT: begin
                    if (rx_valid) begin
                        byte_take = 1'b1;
                        if (byte_last) begin
                            state_next = (count_full != 16'd0) ? ST_DATA : ST_CSUM;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        byte_take = 1'b1;
                        if (byte_last) begin
                            state_next = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // The receiver has no buffering, so any byte while a
                    // write is pending would be lost: treat it as overrun,
                    // even when the ack lands in the same cycle.
                    if (rx_valid) begin
                        state_next = ST_IDLE;
                        abort      = 1'b1;
                        err_set    = 1'b1;
                    end else if (mem_ack) begin
                        write_step = 1'b1;
                        state_next = (word_cnt == 16'd1) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state_next = ST_RUN;
                            done_set   = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            abort      = 1'b1;
                            err_set    = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: field assembly, running checksum, write address/count
    // bookkeeping and the registered status pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_rx_en <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_cnt   <= 2'd0;
            csum       <= 8'd0;
            word_cnt   <= 16'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            uart_rx_en <= 1'b1;
            load_done  <= done_set;
            load_err   <= err_set;

            // Counters start every packet from zero; IDLE is where a new
            // packet begins, so clearing there also covers the SYNC byte.
            if (abort || (state == ST_IDLE)) begin
                byte_cnt <= 2'd0;
                csum     <= 8'd0;
            end else if (byte_take) begin
                csum     <= csum + rx_data;
                byte_cnt <= byte_last ? 2'd0 : byte_cnt + 2'd1;
            end

            if (byte_take) begin
                case (state)
                    ST_ADDR: begin
                        // Low address bits are dropped on the final byte to
                        // keep every write word-aligned.
                        if (byte_last) begin
                            mem_addr <= {rx_data, mem_addr[31:10], 2'b00};
                        end else begin
                            mem_addr <= {rx_data, mem_addr[31:8]};
                        end
                    end
                    ST_CNT: begin
                        word_cnt <= count_full;
                    end
                    ST_DATA: begin
                        mem_wdata <= {rx_data, mem_wdata[31:8]};
                    end
                    default: begin
                    end
                endcase
            end

            if (write_step) begin
                mem_addr <= mem_addr + WORD_STRIDE;
                word_cnt <= word_cnt - 16'd1;
            end

            if (abort) begin
                word_cnt <= 16'd0;
            end
        end
    end

    // The idle timer restarts on every byte, on an abort and when a new
    // packet opens; it is frozen while a write is outstanding.
    assign timer_clear = rx_valid || abort ||
                         ((state_next == ST_ADDR) && (state != ST_ADDR));
    assign timer_run   = timed_state(state);

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (timer_expired)
    );

endmodule

// File: doc/uart_loader_ctrl.md
UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, maximum idle clk cycles between bytes inside a packet.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_valid  input  1  single-cycle pulse: rx_data holds a received byte.
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port rx_break  input  1  BREAK detected on the line; sampled only when rx_valid=1.
REQ-008 SHALL have port uart_rx_en  output  1  receiver enable.
REQ-009 SHALL have port mem_req  output  1  write request; held until mem_ack.
REQ-010 SHALL have port mem_addr  output  32  word-aligned write address.
REQ-011 SHALL have port mem_wdata  output  32  write data.
REQ-012 SHALL have port mem_ack  input  1  memory accepted write in this cycle.
REQ-013 SHALL have port cpu_resetn  output  1  CPU reset, active-low.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse: packet loaded, checksum good.
REQ-015 SHALL have port load_err  output  1  one-cycle pulse: packet aborted.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE and RUN.

Function
REQ-017 SHALL implement packet format: SYNC_BYTE, ADDR[4] LE, COUNT[2] LE (32-bit words), DATA[4*COUNT] LE per word, CSUM[1].
REQ-018 SHALL compute CSUM as 8-bit wrapping sum of all bytes after SYNC up to and including the last DATA byte.
REQ-019 SHALL implement states IDLE, ADDR, CNT, DATA, WRITE, CSUM, RUN.
REQ-020 IDLE: rx_valid with rx_data==SYNC_BYTE -> ADDR; any other byte ignored, no error.
REQ-021 ADDR: after 4th byte -> CNT; ADDR[1:0] forced to 2'b00.
REQ-022 CNT: after 2nd byte -> DATA if COUNT!=0, else CSUM.
REQ-023 DATA: after 4th byte of a word -> WRITE, with mem_req=1 on the next cycle.
REQ-024 WRITE: mem_req, mem_addr, mem_wdata held stable until mem_ack; on the ack cycle address += 4 (wraps modulo 2^32) and word counter decrements; -> DATA if words remain, else CSUM.
REQ-025 rx_valid during WRITE, including on the mem_ack cycle, SHALL abort (overrun).
REQ-026 CSUM: received byte equal to computed sum -> RUN with load_done pulse; mismatch -> IDLE with load_err pulse.
REQ-027 RUN: cpu_resetn=1; SYNC bytes ignored; only rx_break returns to IDLE.
REQ-028 rx_valid with rx_break=1 in any state SHALL go to IDLE with cpu_resetn=0 the next cycle; load_err pulses only if busy was 1.
REQ-029 Inter-byte counter SHALL clear on each rx_valid and on entry to ADDR; in ADDR, CNT, DATA or CSUM, reaching TIMEOUT_CYCLES SHALL abort; the counter SHALL not run in WRITE.
REQ-030 Abort SHALL mean: next state IDLE, mem_req=0, load_err one-cycle pulse, checksum and byte counters cleared.
REQ-031 uart_rx_en SHALL be 1 in all states after reset.
REQ-032 cpu_resetn SHALL be 0 in all states except RUN.

Reset
REQ-033 On resetn=0 SHALL set: state IDLE, mem_req=0, mem_addr=0, mem_wdata=0, cpu_resetn=0, load_done=0, load_err=0, busy=0, uart_rx_en=0, all counters 0.
REQ-034 Reset asserted mid-packet or mid-WRITE SHALL drop mem_req the next cycle without waiting for mem_ack.

Structure
REQ-035 SHALL place state encoding, SYNC_BYTE default and packet field lengths in shared package loader_pkg.
REQ-036 SHALL place the inter-byte timeout counter in sub-module loader_timeout (inputs clear, run; output expired).

Verification
REQ-037 SHALL test: reset deasserted; A5, 00 01 00 00, 02 00, 11 22 33 44, 55 66 77 88, CSUM -> mem writes 0x44332211@0x100 and 0x88776655@0x104, load_done, cpu_resetn=1.
REQ-038 SHALL test: same packet with CSUM+1 -> load_err pulse, cpu_resetn stays 0, state IDLE.
REQ-039 SHALL test: COUNT=0 packet with CSUM=sum(address bytes) -> no mem_req, load_done.
REQ-040 SHALL test: mem_ack delayed 20 cycles with a byte arriving in WRITE -> load_err, mem_req drops.
REQ-041 SHALL test: TIMEOUT_CYCLES=100, line stalls after 2nd ADDR byte -> load_err at cycle 100 after last rx_valid.
REQ-042 SHALL test: in RUN, rx_valid with rx_break=1 -> cpu_resetn=0 next cycle, no load_err; ADDR=FFFFFFFC, COUNT=2 -> second write at 0x00000000.
